sprite_scan: RTL

Per-scanline sprite evaluator for the sprite engine. It walks OAM in index order during horizontal blank and collects the first `SPRITES` sprites that intersect the requested row into a slot buffer. The sprite units then load this buffer and feed `sprite_tournament`. Slot 0 always holds the lowest-index (highest-priority) hit, which matches the tournament's LSB-wins rule.

---
 rtl/sprite_scan.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sprite_scan.sv
// Per-scanline OAM walker: collects the first SPRITES sprites hitting a row into a slot buffer.
// Optional feature macro SPRITE_OVERFLOW_EN: full-length scan with sticky overflow; otherwise stop early when full.
`ifndef MAX_SPRITES_PER_LINE
`define MAX_SPRITES_PER_LINE 8
`endif

module sprite_scan #(
  parameter int SPRITES     = `MAX_SPRITES_PER_LINE,
  parameter int OAM_ENTRIES = 64,
  parameter int SPRITE_H    = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [7:0]                             row,
  output logic [$clog2(OAM_ENTRIES)-1:0]         oam_addr,
  input  logic [31:0]                            oam_data,
  output logic [SPRITES*32-1:0]                  slot_entry,
  output logic [SPRITES*$clog2(SPRITE_H)-1:0]    slot_yoff,
  output logic [SPRITES-1:0]                     slot_valid,
  output logic [$clog2(SPRITES):0]               count,
  output logic                                   overflow,
  output logic                                   busy,
  output logic                                   done
);

  localparam int AW = $clog2(OAM_ENTRIES);
  localparam int YW = $clog2(SPRITE_H);
  localparam int CW = $clog2(SPRITES) + 1;
  localparam int SW = $clog2(SPRITES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(OAM_ENTRIES - 1);
  localparam logic [CW-1:0] FULL      = CW'(SPRITES);
  localparam logic [8:0]    H_LIM     = 9'(SPRITE_H);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [7:0]          row_q, row_d;
  logic                inflight_q, inflight_d;
  logic [CW-1:0]       count_q, count_d;
  logic [SPRITES-1:0]  valid_q, valid_d;
  logic [31:0]         entry_q [SPRITES];
  logic [31:0]         entry_d [SPRITES];
  logic [YW-1:0]       yoff_q [SPRITES];
  logic [YW-1:0]       yoff_d [SPRITES];
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          dist_s;
  logic                hit_s;

  // Row distance wraps mod 256 so sprites near y=255 reach the top rows.
  assign dist_s = row_q - oam_data[16:9];
  assign hit_s  = inflight_q && ({1'b0, dist_s} < H_LIM);

  // Next-state, slot write and hit evaluation for the word returned this cycle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    row_d      = row_q;
    inflight_d = 1'b0;
    count_d    = count_q;
    valid_d    = valid_q;
    entry_d    = entry_q;
    yoff_d     = yoff_q;
    ovf_d      = ovf_q;

    if (hit_s && (count_q < FULL)) begin
      entry_d[count_q[SW-1:0]] = oam_data;
      yoff_d[count_q[SW-1:0]]  = dist_s[YW-1:0];
      valid_d[count_q[SW-1:0]] = 1'b1;
      count_d                  = count_q + CW'(1'b1);
    end else begin
      ovf_d = ovf_q | hit_s;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          addr_d  = {AW{1'b0}};
          row_d   = row;
          count_d = {CW{1'b0}};
          valid_d = {SPRITES{1'b0}};
          ovf_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        inflight_d = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = S_FLUSH;
        end else begin
          addr_d = addr_q + AW'(1'b1);
        end
`ifndef SPRITE_OVERFLOW_EN
        // Buffer full: the word still in flight finds no free slot and is dropped.
        if (count_d == FULL) begin
          state_d = S_FLUSH;
        end else begin
          state_d = state_d;
        end
`endif
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= {AW{1'b0}};
      row_q      <= 8'd0;
      inflight_q <= 1'b0;
      count_q    <= {CW{1'b0}};
      valid_q    <= {SPRITES{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < SPRITES; i++) begin
        entry_q[i] <= 32'd0;
        yoff_q[i]  <= {YW{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_q      <= row_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      entry_q    <= entry_d;
      yoff_q     <= yoff_d;
    end
  end

  for (genvar g = 0; g < SPRITES; g++) begin : g_pack
    assign slot_entry[g*32 +: 32] = entry_q[g];
    assign slot_yoff[g*YW +: YW]  = yoff_q[g];
  end

  assign oam_addr   = addr_q;
  assign slot_valid = valid_q;
  assign count      = count_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef SPRITE_OVERFLOW_EN
  assign overflow   = ovf_q;
`else
  assign overflow   = 1'b0;
`endif

endmodule
